// File: rtl/vsq_accumulator.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | vsq_accumulator: sums a run of VSQ-scaled partial sums into one         |
// | saturating dot-product result on a valid/ready port.  Rev 1.0           |
// +------------------------------------------------------------------------+
module vsq_accumulator #(
  parameter int IN_W  = 24,
  parameter int ACC_W = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [CNT_W-1:0] num_vec,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  partial_sum_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             out_sat
);

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             sat_q, sat_d;

  logic             w_beat;
  logic             w_first;
  logic             w_last;
  logic [CNT_W-1:0] w_len;
  logic [ACC_W-1:0] w_in_ext;
  logic [ACC_W:0]   w_sum;

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign acc_out   = acc_q;
  assign out_sat   = sat_q;

  assign w_beat   = in_valid & in_ready;
  assign w_first  = (cnt_q == '0);
  assign w_in_ext = ACC_W'(partial_sum_in);
  assign w_sum    = {1'b0, acc_q} + {1'b0, w_in_ext};

  // Group length is taken from num_vec only on the first beat; zero means one.
  assign w_len  = w_first ? ((num_vec == '0) ? CNT_W'(1) : num_vec) : len_q;
  assign w_last = (cnt_q == (w_len - CNT_W'(1)));

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    sat_d   = sat_q;

    case (state_q)
      ACCUM: begin
        if (w_beat) begin
          cnt_d = w_last ? '0 : (cnt_q + CNT_W'(1));
          if (w_first) begin
            len_d = w_len;
            acc_d = w_in_ext;
            sat_d = 1'b0;
          end else if (sat_q || w_sum[ACC_W]) begin
            acc_d = '1;
            sat_d = 1'b1;
          end else begin
            acc_d = w_sum[ACC_W-1:0];
          end
          if (w_last) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase

    // Abort wins over any beat or pending result in the same cycle.
    if (flush) begin
      state_d = ACCUM;
      cnt_d   = '0;
      acc_d   = '0;
      sat_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      sat_q   <= sat_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vsq_accumulator.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_vsq_accumulator: randomized and directed bench for vsq_accumulator.  |
// | Rev 1.0                                                                 |
// +------------------------------------------------------------------------+
module tb_vsq_accumulator;

  localparam int IN_W  = 24;
  localparam int ACC_W = 32;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic [CNT_W-1:0] num_vec;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  partial_sum_in;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] acc_out;
  logic             out_sat;

  vsq_accumulator #(.IN_W(IN_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) u_dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .num_vec        (num_vec),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .partial_sum_in (partial_sum_in),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .acc_out        (acc_out),
    .out_sat        (out_sat)
  );

  always #5 clk = ~clk;

  int               n_checks = 0;
  int               n_fail   = 0;
  logic [IN_W-1:0]  beats[$];
  logic [ACC_W-1:0] exp_acc;
  logic             exp_sat;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain sum of the group, clamped to the result range.
  task automatic model();
    longint unsigned s;
    longint unsigned lim;
    s   = 0;
    lim = (64'd1 << ACC_W) - 64'd1;
    foreach (beats[i]) s += 64'(beats[i]);
    exp_sat = (s > lim);
    exp_acc = exp_sat ? '1 : ACC_W'(s);
  endtask

  task automatic fill(input int n, input logic [IN_W-1:0] v);
    beats = {};
    for (int i = 0; i < n; i++) beats.push_back(v);
  endtask

  // Feeds every entry of beats; num_vec is scrambled after the first beat.
  task automatic send_beats(input int nv, input bit gaps);
    int t;
    foreach (beats[i]) begin
      if (gaps && ($urandom_range(0, 3) == 0)) begin
        in_valid = 1'b0;
        step();
      end
      num_vec        = (i == 0) ? CNT_W'(nv) : CNT_W'($urandom);
      in_valid       = 1'b1;
      partial_sum_in = beats[i];
      t = 0;
      while (!in_ready && t < 50) begin
        step();
        t++;
      end
      if (t >= 50) chk("in_ready_timeout", 64'(in_ready), 64'd1);
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic check_result(input string tag);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_acc"}, 64'(acc_out), 64'(exp_acc));
    chk({tag, "_sat"}, 64'(out_sat), 64'(exp_sat));
    chk({tag, "_inrdy_low"}, 64'(in_ready), 64'd0);
  endtask

  task automatic consume(input int stall);
    out_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      step();
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_acc", 64'(acc_out), 64'(exp_acc));
      chk("stall_inrdy", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("consumed_valid", 64'(out_valid), 64'd0);
    chk("consumed_inrdy", 64'(in_ready), 64'd1);
  endtask

  task automatic run(input string tag, input int nv, input int stall, input bit gaps);
    model();
    send_beats(nv, gaps);
    check_result(tag);
    consume(stall);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_acc"}, 64'(acc_out), 64'd0);
    chk({tag, "_sat"}, 64'(out_sat), 64'd0);
    chk({tag, "_inrdy"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nv, n;
    rst = 1'b1; flush = 1'b0; num_vec = '0; in_valid = 1'b0;
    partial_sum_in = '0; out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    check_idle("reset");

    beats = {24'd10, 24'd20, 24'd30, 24'd40};
    run("basic4", 4, 0, 1'b0);

    fill(1, 24'hFFFFFF);
    run("nv0", 0, 0, 1'b0);
    run("nv1", 1, 1, 1'b0);

    fill(257, 24'hFFFFFF);
    run("sat257", 257, 0, 1'b0);
    beats = {24'd5, 24'd5};
    run("after_sat", 2, 0, 1'b0);

    // Backpressure with the next group's beat held at the input
    beats = {24'd7, 24'd8};
    model();
    send_beats(2, 1'b0);
    check_result("bp");
    in_valid = 1'b1; partial_sum_in = 24'd9; num_vec = CNT_W'(1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
      chk("bp_hold_acc", 64'(acc_out), 64'd15);
      chk("bp_hold_inrdy", 64'(in_ready), 64'd0);
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_release_valid", 64'(out_valid), 64'd0);
    chk("bp_release_inrdy", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    beats = {24'd9};
    model();
    check_result("bp_next");
    consume(0);

    // Flush mid-group, with a beat presented in the flush cycle
    beats = {24'd3, 24'd4};
    send_beats(4, 1'b0);
    flush = 1'b1; in_valid = 1'b1; partial_sum_in = 24'd50; num_vec = CNT_W'(1);
    chk("flush_inrdy", 64'(in_ready), 64'd1);
    step();
    flush = 1'b0; in_valid = 1'b0;
    check_idle("flush_mid");
    beats = {24'd1, 24'd2};
    run("post_flush", 2, 0, 1'b0);

    beats = {24'd77};
    model();
    send_beats(1, 1'b0);
    check_result("pre_flush_done");
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_idle("flush_done");

    // Reset mid-group and while a result is pending
    beats = {24'd100, 24'd200};
    send_beats(4, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_idle("rst_mid");
    beats = {24'd1, 24'd2, 24'd3};
    run("post_rst", 3, 0, 1'b0);

    beats = {24'd9};
    model();
    send_beats(1, 1'b0);
    check_result("pre_rst_done");
    rst = 1'b1; out_ready = 1'b1;
    step();
    rst = 1'b0; out_ready = 1'b0;
    check_idle("rst_done");
    beats = {24'd11, 24'd12};
    run("post_rst2", 2, 0, 1'b0);

    for (int g = 0; g < 30; g++) begin
      beats = {};
      if ($urandom_range(0, 9) == 0) begin
        nv = $urandom_range(250, 300);
        for (int i = 0; i < nv; i++) beats.push_back(IN_W'($urandom_range(24'hF00000, 24'hFFFFFF)));
      end else begin
        nv = $urandom_range(0, 8);
        n  = (nv == 0) ? 1 : nv;
        for (int i = 0; i < n; i++) beats.push_back(IN_W'($urandom));
      end
      run("rand", nv, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vsq_accumulator.md
Name: vsq_accumulator

Overview:
Downstream stage of the VSQ scaling block. Consumes the 24-bit scaled partial sums produced per vector block and accumulates a run of them into one ACC_W-bit dot-product result. Emits the result on a valid/ready output port. Saturates on overflow and flags it. Sits between VSQ scaling and the output writeback buffer of the PE column.

Parameters:
IN_W, 24, width of incoming scaled partial sum (unsigned)
ACC_W, 32, accumulator/result width; must be >= IN_W
CNT_W, 8, width of vector-count config and beat counter

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
flush  input  1  synchronous abort of current group; higher priority than inputs, lower than rst
num_vec  input  CNT_W  number of partial sums per group; sampled on first accepted beat of a group
in_valid  input  1  partial sum valid
in_ready  output  1  block can accept a beat
partial_sum_in  input  IN_W  scaled partial sum from VSQ stage, unsigned
out_valid  output  1  acc_out/out_sat valid
out_ready  input  1  downstream accepts result
acc_out  output  ACC_W  accumulated result
out_sat  output  1  result saturated during this group

Behaviour:
- Reset (rst=1 at clk edge): state=ACCUM, acc=0, cnt=0, len=0, sat=0; in_ready=1 from the next cycle, out_valid=0, acc_out=0, out_sat=0.
- Two states: ACCUM, DONE. in_ready = (state==ACCUM). out_valid = (state==DONE). No combinational path from out_ready to in_ready.
- Beat accepted when in_valid & in_ready.
- First beat of a group (cnt==0): len latched as num_vec. num_vec==0 is treated as 1. acc = zero-extended partial_sum_in. sat=0.
- Subsequent beats: sum = acc + zero-extended partial_sum_in, computed at ACC_W+1 bits. On carry out, acc = all ones and sat=1 (sticky for the group). Once saturated, acc stays all ones.
- cnt increments per accepted beat. The beat with cnt==len-1 (or the single beat for len<=1) moves state to DONE and resets cnt=0.
- Latency: acc_out and out_sat are valid the cycle after the last beat is accepted. They hold stable while out_valid=1 and out_ready=0.
- DONE with out_ready=1: result consumed, state goes to ACCUM next cycle, and acc_out holds its last value. This causes one bubble cycle between the last beat of group N and the first beat of group N+1.
- num_vec changes mid-group are ignored; only the sample taken at the first beat is used.
- flush=1 (no rst): state=ACCUM, cnt=0, acc=0, sat=0, out_valid=0. A pending result in DONE is discarded. Any beat presented in the same cycle is dropped, and in_ready is still 1 that cycle.
- rst overrides flush and in-flight handshakes. Reset mid-group loses the partial accumulation; no output is produced.
- Inputs in DONE are not accepted; upstream must hold in_valid/data stable (standard valid/ready).

Test Plan:
- Reset, then num_vec=4 with beats 10,20,30,40 back-to-back, out_ready=1 -> out_valid one cycle after 4th beat, acc_out=100, out_sat=0; in_ready low for exactly 1 cycle.
- num_vec=0 then num_vec=1, each with single beat 0xFFFFFF -> two results, each acc_out=0x00FFFFFF; num_vec=0 behaves identically to 1.
- ACC_W=32, num_vec=3, beats 0xFFFFFF each with acc preloaded by prior beats of 0xFFFFFF over 257 beats (num_vec=255+ variant with CNT_W=16) -> acc_out=0xFFFFFFFF, out_sat=1; next group of 2 beats of 5 -> acc_out=10, out_sat=0.
- Backpressure: num_vec=2, beats 7,8, out_ready=0 for 5 cycles -> out_valid held, acc_out=15 stable, in_ready=0 throughout, in_valid beat not consumed; on out_ready=1, group 2 proceeds normally.
- flush after 2 of 4 beats (3,4) -> no output; the new group of num_vec=2, beats 1,2 -> acc_out=3. flush in DONE -> out_valid drops next cycle, result lost.
- rst asserted mid-group and during DONE -> all outputs return to reset values next cycle; the following group accumulates from 0 correctly; num_vec change mid-group has no effect on the group length.
